// File: rtl/pair_max_ctrl.sv
// pair_max_ctrl: sequences a pairwise max transfer from source memory A to destination memory B.
//
// Words are read from A two at a time. The even word goes into operand register DOut1 and the
// odd word into DOut2. After one settling cycle the external comparator's Sign result picks the
// larger word, which is written to B at the pair index. GtCount counts the pairs whose even word
// was strictly larger.
//
// Ports:
//   Clk      clock, rising edge
//   Rst      synchronous active-high reset
//   Start    begin a transfer (only looked at in idle)
//   Busy     high in every state except idle
//   Done     one-cycle pulse after the last pair is written
//   RdA      source read enable
//   AddrA    source address ({k,0} then {k,1})
//   DInA     source read data, valid the cycle after RdA/AddrA
//   DOut1    comparator operand, even word A[2k]
//   DOut2    comparator operand, odd word A[2k+1]
//   Sign     comparator result, 1 iff DOut2 < DOut1 (unsigned)
//   WeB      destination write enable
//   AddrB    destination address (pair index k)
//   DOutB    destination write data
//   GtCount  pairs with Sign=1 in the current or last transfer
module pair_max_ctrl #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 8
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Start,
    output logic              Busy,
    output logic              Done,
    output logic              RdA,
    output logic [ADDR_W-1:0] AddrA,
    input  logic [DATA_W-1:0] DInA,
    output logic [DATA_W-1:0] DOut1,
    output logic [DATA_W-1:0] DOut2,
    input  logic              Sign,
    output logic              WeB,
    output logic [ADDR_W-2:0] AddrB,
    output logic [DATA_W-1:0] DOutB,
    output logic [ADDR_W-1:0] GtCount
);

    typedef enum logic [2:0] {
        StIdle,
        StRd1,
        StRd2,
        StCap,
        StCmp,
        StWr,
        StDone
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-2:0] k_q, k_d;
    logic [DATA_W-1:0] dout1_q, dout1_d;
    logic [DATA_W-1:0] dout2_q, dout2_d;
    logic [ADDR_W-1:0] gt_q, gt_d;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= StIdle;
            k_q     <= '0;
            dout1_q <= '0;
            dout2_q <= '0;
            gt_q    <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            dout1_q <= dout1_d;
            dout2_q <= dout2_d;
            gt_q    <= gt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        dout1_d = dout1_q;
        dout2_d = dout2_q;
        gt_d    = gt_q;
        Done    = 1'b0;
        RdA     = 1'b0;
        AddrA   = '0;
        WeB     = 1'b0;
        AddrB   = '0;
        DOutB   = '0;

        unique case (state_q)
            StIdle: begin
                if (Start) begin
                    k_d     = '0;
                    gt_d    = '0;
                    state_d = StRd1;
                end
            end
            StRd1: begin
                RdA     = 1'b1;
                AddrA   = {k_q, 1'b0};
                state_d = StRd2;
            end
            StRd2: begin
                // DInA now carries the even word requested in the previous cycle.
                RdA     = 1'b1;
                AddrA   = {k_q, 1'b1};
                dout1_d = DInA;
                state_d = StCap;
            end
            StCap: begin
                dout2_d = DInA;
                state_d = StCmp;
            end
            StCmp: begin
                state_d = StWr;
            end
            StWr: begin
                WeB   = 1'b1;
                AddrB = k_q;
                // Equal words give Sign=0, so the odd word is written.
                DOutB = Sign ? dout1_q : dout2_q;
                if (Sign) begin
                    gt_d = gt_q + ADDR_W'(1);
                end
                if (&k_q) begin
                    state_d = StDone;
                end else begin
                    k_d     = k_q + (ADDR_W - 1)'(1);
                    state_d = StRd1;
                end
            end
            StDone: begin
                Done    = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign Busy    = (state_q != StIdle);
    assign DOut1   = dout1_q;
    assign DOut2   = dout2_q;
    assign GtCount = gt_q;

endmodule

// File: tb/tb_pair_max_ctrl.sv
module tb_pair_max_ctrl;
    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;
    localparam int NWORD  = 1 << ADDR_W;
    localparam int NPAIR  = NWORD / 2;

    logic              Clk;
    logic              Rst;
    logic              Start;
    logic              Busy;
    logic              Done;
    logic              RdA;
    logic [ADDR_W-1:0] AddrA;
    logic [DATA_W-1:0] DInA;
    logic [DATA_W-1:0] DOut1;
    logic [DATA_W-1:0] DOut2;
    logic              Sign;
    logic              WeB;
    logic [ADDR_W-2:0] AddrB;
    logic [DATA_W-1:0] DOutB;
    logic [ADDR_W-1:0] GtCount;

    pair_max_ctrl #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) dut (
        .Clk    (Clk),
        .Rst    (Rst),
        .Start  (Start),
        .Busy   (Busy),
        .Done   (Done),
        .RdA    (RdA),
        .AddrA  (AddrA),
        .DInA   (DInA),
        .DOut1  (DOut1),
        .DOut2  (DOut2),
        .Sign   (Sign),
        .WeB    (WeB),
        .AddrB  (AddrB),
        .DOutB  (DOutB),
        .GtCount(GtCount)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    // Source RAM with one-cycle registered read, and the unsigned comparator.
    logic [DATA_W-1:0] mem [NWORD];
    always @(posedge Clk) if (RdA) DInA <= mem[AddrA];
    assign Sign = (DOut2 < DOut1);

    typedef struct {
        logic [ADDR_W-2:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    wr_t sb[$];
    int  tests = 0;
    int  fails = 0;
    int  wr_cnt = 0;
    int  done_cnt = 0;
    int  exp_done_cyc = -1;
    logic [ADDR_W-1:0] exp_gt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops the expected write for every WeB and checks Done timing/count.
    always @(negedge Clk) begin
        wr_t e;
        if (WeB === 1'b1) begin
            wr_cnt++;
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_write: got addr %0d data %h expected no write",
                         AddrB, DOutB);
            end else begin
                e = sb.pop_front();
                check("write_addr", 32'(AddrB), 32'(e.addr));
                check("write_data", 32'(DOutB), 32'(e.data));
            end
        end
        if (Done === 1'b1) begin
            done_cnt++;
            check("done_cycle", cyc, exp_done_cyc);
            check("done_gtcount", 32'(GtCount), 32'(exp_gt));
            check("done_sb_empty", sb.size(), 0);
        end
    end

    function automatic logic [DATA_W-1:0] maxw(input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b);
        return (a > b) ? a : b;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, 32'(Busy), 0);
        check({tag, "_done"}, 32'(Done), 0);
        check({tag, "_rda"}, 32'(RdA), 0);
        check({tag, "_web"}, 32'(WeB), 0);
        check({tag, "_addra"}, 32'(AddrA), 0);
        check({tag, "_addrb"}, 32'(AddrB), 0);
        check({tag, "_doutb"}, 32'(DOutB), 0);
        check({tag, "_dout1"}, 32'(DOut1), 0);
        check({tag, "_dout2"}, 32'(DOut2), 0);
        check({tag, "_gtcount"}, 32'(GtCount), 0);
    endtask

    // One transfer. abort: reset in the CAP cycle of pair 2. poke: Start pulse during pair 3.
    task automatic run(input bit abort, input bit poke);
        int n_wr;
        int start_cyc;
        int w0;
        int d0;
        int n;
        logic [ADDR_W-1:0] gt;
        n_wr = abort ? 2 : NPAIR;
        gt   = '0;
        for (int k = 0; k < NPAIR; k++) begin
            if (mem[2*k] > mem[2*k+1]) gt++;
            if (k < n_wr) sb.push_back('{addr: (ADDR_W-1)'(k), data: maxw(mem[2*k], mem[2*k+1])});
        end
        w0 = wr_cnt;
        d0 = done_cnt;

        @(negedge Clk);
        Start = 1'b1;
        @(posedge Clk);
        #1 Start = 1'b0;
        start_cyc = cyc;
        // RD1 is cycle t+1 here; Done lands 5*NPAIR cycles later.
        exp_gt       = gt;
        exp_done_cyc = abort ? -1 : start_cyc + 5 * NPAIR;
        @(negedge Clk);
        check("rd1_busy", 32'(Busy), 1);
        check("rd1_rda", 32'(RdA), 1);
        check("rd1_addra", 32'(AddrA), 0);

        if (abort) begin
            while (cyc < start_cyc + 12) @(negedge Clk);
            check("cap_rda", 32'(RdA), 0);
            Rst = 1'b1;
            @(posedge Clk);
            #1 Rst = 1'b0;
            @(negedge Clk);
            check_reset_outputs("abort");
            repeat (12) @(negedge Clk);
            check("abort_writes", wr_cnt - w0, 2);
            check("abort_idle", 32'(Busy), 0);
            check("abort_no_done", done_cnt - d0, 0);
            sb.delete();
            return;
        end

        if (poke) begin
            while (cyc < start_cyc + 16) @(negedge Clk);
            Start = 1'b1;
            @(negedge Clk);
            Start = 1'b0;
        end

        n = 0;
        while (done_cnt == d0 && n < 60) begin
            @(negedge Clk);
            n++;
        end
        check("done_seen", done_cnt - d0, 1);
        @(negedge Clk);
        check("post_busy", 32'(Busy), 0);
        check("post_writes", wr_cnt - w0, NPAIR);
        check("post_dout1", 32'(DOut1), 32'(mem[NWORD-2]));
        check("post_dout2", 32'(DOut2), 32'(mem[NWORD-1]));
        check("post_gtcount", 32'(GtCount), 32'(gt));
        sb.delete();
    endtask

    task automatic fill_random(input bit narrow);
        for (int i = 0; i < NWORD; i++) begin
            mem[i] = narrow ? DATA_W'($urandom_range(0, 3)) : DATA_W'($urandom);
        end
    endtask

    initial begin
        Rst   = 1'b1;
        Start = 1'b1;
        for (int i = 0; i < NWORD; i++) mem[i] = '0;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        check_reset_outputs("reset");
        Rst   = 1'b0;
        Start = 1'b0;
        repeat (2) @(negedge Clk);

        // Corner pairs: greater, equal, odd-larger, extremes; extremes also last for hold check.
        fill_random(1'b0);
        mem[0] = 8'h01; mem[1] = 8'h00;
        mem[2] = 8'h00; mem[3] = 8'h00;
        mem[4] = 8'h00; mem[5] = 8'h01;
        mem[6] = 8'hFF; mem[7] = 8'h7F;
        mem[14] = 8'hFF; mem[15] = 8'h7F;
        run(1'b0, 1'b0);

        for (int i = 0; i < NWORD; i++) mem[i] = DATA_W'(i) ^ 8'h5A;
        run(1'b0, 1'b0);

        for (int r = 0; r < 4; r++) begin
            fill_random(r[0]);
            run(1'b0, 1'b0);
        end

        fill_random(1'b0);
        run(1'b0, 1'b1);

        fill_random(1'b0);
        run(1'b1, 1'b0);
        fill_random(1'b0);
        run(1'b0, 1'b0);

        repeat (3) @(negedge Clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
